ws2812_pixel_serializer: RTL
============================

# ws2812_pixel_serializer

Bit-level line encoder for a WS2812b LED chain. It takes 24-bit pixel words over a valid/ready stream, emits each bit MSB-first as a fixed-period NRZ pulse with data-dependent high time, and ends every frame with a low latch gap. It sits directly downstream of the pixel sequencer (the Avalon register bank and LED counter) and drives the `led_dout` pin.

## Interface
- `LED_DATA_W`, 24: pixel width in bits; sent MSB first (GRB order is the upstream's job).
- `T0H_CYC`, 20: high time of a '0' bit, in clk cycles (400 ns at 50 MHz).
- `T1H_CYC`, 40: high time of a '1' bit, in clk cycles (800 ns).
- `TBIT_CYC`, 63: total bit period, in clk cycles (1.26 µs). Legal only if 0 < T0H_CYC < T1H_CYC < TBIT_CYC.
- `TRST_CYC`, 15000: latch gap, in clk cycles (300 µs). Must be ≥ 1.
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `pix_data`  in  LED_DATA_W  pixel word.
- `pix_valid`  in  1  upstream holds a pixel.
- `pix_last`  in  1  qualifies `pix_data` as the final pixel of the frame.
- `pix_ready`  out  1  serializer accepts this cycle. Transfer happens when valid & ready.
- `led_dout`  out  1  registered line output to the chain.
- `busy`  out  1  high whenever state ≠ IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of the latch gap.
- `underrun`  out  1  one-cycle pulse when a non-last pixel ends and no next pixel is offered.

## Operation
- Registers: shift register (LED_DATA_W), bit counter (0..LED_DATA_W-1), last flag, and one shared cycle counter sized for max(TBIT_CYC, TRST_CYC).
- States: IDLE, BIT, LATCH.
- IDLE: `pix_ready`=1 and `led_dout`=0. On a transfer, load the shift register with `pix_data`, the last flag with `pix_last`, bitcnt=LED_DATA_W-1 and cyc=0, then go to BIT.
- BIT: `led_dout` is registered from (cyc < (shift[MSB] ? T1H_CYC : T0H_CYC)). cyc counts 0..TBIT_CYC-1. At cyc=TBIT_CYC-1:
  - bitcnt>0: shift left by 1, decrement bitcnt, cyc=0.
  - bitcnt=0 and last flag set: go to LATCH with cyc=0.
  - bitcnt=0, last flag clear, transfer this cycle: reload as in IDLE and stay in BIT. There is no gap between pixels.
  - bitcnt=0, last flag clear, no valid: pulse `underrun` and go to LATCH. The partial frame is latched.
- In BIT, `pix_ready`=1 only in the cycle where cyc=TBIT_CYC-1, bitcnt=0 and the last flag is clear. Otherwise it is 0.
- LATCH: `led_dout`=0 and `pix_ready`=0. cyc counts 0..TRST_CYC-1. At TRST_CYC-1, pulse `frame_done` and go to IDLE.
- `pix_data` and `pix_last` are sampled only on a transfer. The upstream may change them freely at any other time.
- `pix_valid` arriving during LATCH is held off by `pix_ready`=0 and is accepted in IDLE.

## Timing
- Reset values: state=IDLE, `led_dout`=0, `busy`=0, `frame_done`=0, `underrun`=0, `pix_ready`=1 from the first cycle after reset. All counters are 0.
- Transfer at edge N: `led_dout` goes high at edge N+1. `busy`=1 from edge N+1.
- Each bit is exactly TBIT_CYC cycles. '0' is high for T0H_CYC cycles, '1' is high for T1H_CYC cycles.
- Each pixel is LED_DATA_W·TBIT_CYC cycles (1512 at defaults).
- A back-to-back transfer keeps the bit period seamless: the next pixel's first high cycle immediately follows the previous pixel's last bit period.
- From the end of the last bit of a frame to `frame_done` is TRST_CYC cycles. `busy` drops and `pix_ready` rises on the edge after `frame_done`.
- Reset mid-frame takes effect at the next edge: `led_dout`=0, IDLE, no `frame_done`, no `underrun`.
- `frame_done` and `underrun` never assert in the same cycle. `underrun` precedes its `frame_done` by TRST_CYC cycles.

## Test plan
- Single pixel 0xA5_0000 with last=1: bits 1,0,1,0,0,1,0,1 then 16 zeros. High times must read 40,20,40,20,20,40,20,40,20×16 cycles at a 63-cycle pitch, followed by 15000 low cycles and one `frame_done` pulse.
- Three pixels 0xFFFFFF, 0x000000, 0x800001 (last on the third), valid held high: `pix_ready` is seen exactly at the two pixel boundaries plus IDLE, there are no gaps, and total busy time is 3·1512+15000 cycles.
- Underrun: first pixel with last=0, then valid withheld: `underrun` pulses at cycle 1512 after the first dout rise, and `frame_done` follows 15000 cycles later.
- Reset asserted at bit 10 of a pixel: `led_dout`=0, `busy`=0 and `pix_ready`=1 on the next edge. No `frame_done` pulse, and a new pixel is accepted normally afterwards.
- Valid raised during LATCH: not accepted until the cycle after `frame_done`, and its dout rise follows 1 cycle after that acceptance.
- Data toggled while `pix_ready`=0: the output waveform is unchanged, confirming sampling happens only on transfer.

Source files
------------

// File: rtl/ws2812_pixel_serializer.sv
// ws2812_pixel_serializer: streams 24-bit pixels MSB-first as WS2812 NRZ bit pulses, then a latch gap
module ws2812_pixel_serializer #(
  parameter int LED_DATA_W = 24,
  parameter int T0H_CYC    = 20,
  parameter int T1H_CYC    = 40,
  parameter int TBIT_CYC   = 63,
  parameter int TRST_CYC   = 15000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LED_DATA_W-1:0] pix_data,
  input  logic                  pix_valid,
  input  logic                  pix_last,
  output logic                  pix_ready,
  output logic                  led_dout,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);
  localparam int MAXC = TBIT_CYC > TRST_CYC ? TBIT_CYC : TRST_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam int BW = $clog2(LED_DATA_W + 1);
  localparam logic [CW-1:0] T0H = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H = CW'(T1H_CYC);
  localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] TRST_LAST = CW'(TRST_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(LED_DATA_W - 1);
  typedef enum logic [1:0] {IDLE, BIT, LATCH} state_t;
  state_t                state_q, state_d;
  logic [LED_DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]         bitcnt_q, bitcnt_d;
  logic                  last_q, last_d;
  logic [CW-1:0]         cyc_q, cyc_d;
  logic                  led_dout_q, led_dout_d;
  assign led_dout = led_dout_q;
  assign busy = state_q != IDLE;
  // next-state, handshake and pulse outputs; dout is precomputed from next-state so it lines up with cyc
  always_comb begin
    pix_ready = state_q == IDLE || (state_q == BIT && cyc_q == TBIT_LAST && bitcnt_q == '0 && !last_q);
    frame_done = state_q == LATCH && cyc_q == TRST_LAST;
    underrun = pix_ready && state_q == BIT && !pix_valid;
    state_d = state_q;
    shift_d = shift_q;
    bitcnt_d = bitcnt_q;
    last_d = last_q;
    cyc_d = cyc_q + 1'b1;
    if (pix_valid && pix_ready) begin
      state_d = BIT;
      shift_d = pix_data;
      last_d = pix_last;
      bitcnt_d = BIT_LAST;
      cyc_d = '0;
    end else if (state_q == IDLE) begin
      cyc_d = cyc_q;
    end else if (frame_done) begin
      state_d = IDLE;
      cyc_d = '0;
    end else if (state_q == BIT && cyc_q == TBIT_LAST) begin
      cyc_d = '0;
      if (bitcnt_q != '0) begin
        shift_d = shift_q << 1;
        bitcnt_d = bitcnt_q - 1'b1;
      end else begin
        state_d = LATCH;
      end
    end
    led_dout_d = state_d == BIT && cyc_d < (shift_d[LED_DATA_W-1] ? T1H : T0H);
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bitcnt_q <= '0;
      last_q <= 1'b0;
      cyc_q <= '0;
      led_dout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bitcnt_q <= bitcnt_d;
      last_q <= last_d;
      cyc_q <= cyc_d;
      led_dout_q <= led_dout_d;
    end
  end
endmodule
